instruction_fetch_controller: RTL

Sequences the combinational instruction memory for the single-issue RISC-V core. Owns the program counter and drives the memory address. Captures the returned 32-bit word into a 2-entry fetch buffer. Presents instructions to decode over a valid/ready handshake, with branch redirect, flush and halt control.

---
 rtl/instruction_fetch_controller_pkg.sv | 26 ++
 rtl/instruction_fetch_controller_buffer.sv | 63 ++++++
 rtl/instruction_fetch_controller.sv | 88 ++++++++
 3 files changed

// File: rtl/instruction_fetch_controller_pkg.sv
// Shared definitions for the instruction fetch controller: widths, FSM
// state encoding, buffer entry layout and PC alignment helper.
package instruction_fetch_controller_pkg;

  localparam int unsigned XLEN            = 64;
  localparam int unsigned ILEN            = 32;
  localparam int unsigned PC_STEP         = 4;
  localparam int unsigned FETCH_BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Instructions are word aligned; the two low address bits are always zero.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/instruction_fetch_controller_buffer.sv
// Two-entry shift FIFO of {PC, instruction}. Entry 0 is always the head.
// Flush wins over push; a pop in a flushed cycle is still a delivery.
module fetch_buffer
  import instruction_fetch_controller_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output logic [1:0]   count,
  output logic         head_valid,
  output fetch_entry_t head_entry
);

  fetch_entry_t entry0;
  fetch_entry_t entry1;

  // Storage and occupancy update; pop only happens when non-empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      entry0 <= '0;
      entry1 <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            entry0 <= push_entry;
            count  <= count + 2'd1;
          end else if (count < 2'(FETCH_BUF_DEPTH)) begin
            entry1 <= push_entry;
            count  <= count + 2'd1;
          end
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop keeps occupancy; new word lands behind the survivor.
          if (count == 2'd1) begin
            entry0 <= push_entry;
          end else begin
            entry0 <= entry1;
            entry1 <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  // Head presentation; zeros when empty.
  always_comb begin
    head_valid = (count != 2'd0);
    head_entry = head_valid ? entry0 : '0;
  end

endmodule

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch controller: owns the PC, drives the combinational
// instruction memory and feeds decode from a 2-entry fetch buffer.
module instruction_fetch_controller
  import instruction_fetch_controller_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic [63:0] IMEM_ADDR,
  input  logic [31:0] IMEM_DATA,
  input  logic        HALT,
  input  logic        REDIRECT,
  input  logic [63:0] REDIRECT_PC,
  output logic        INSTR_VALID,
  output logic [31:0] INSTR,
  output logic [63:0] INSTR_PC,
  input  logic        INSTR_READY
);

  fetch_state_t    state;
  fetch_state_t    next_state;
  logic [XLEN-1:0] pc;
  logic            fetch_en;
  logic            redirect_en;
  logic            push;
  logic            pop;
  logic [1:0]      count;
  fetch_entry_t    head_entry;
  fetch_entry_t    push_entry;

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= BOOT;
    else        state <= next_state;
  end

  // Next-state: BOOT always leaves on the first edge; RUN/HALTED follow HALT.
  always_comb begin
    next_state = state;
    unique case (state)
      BOOT:    next_state = RUN;
      RUN:     if (HALT)  next_state = HALTED;
      HALTED:  if (!HALT) next_state = RUN;
      default: next_state = BOOT;
    endcase
  end

  // FSM outputs: fetch permission and redirect acceptance.
  always_comb begin
    fetch_en    = (state == RUN) && !HALT;
    redirect_en = (state != BOOT) && REDIRECT;
  end

  // Handshake and push decision; redirect suppresses the push.
  always_comb begin
    pop        = INSTR_VALID && INSTR_READY;
    push       = fetch_en && !redirect_en && ((count < 2'(FETCH_BUF_DEPTH)) || pop);
    push_entry = '{pc: pc, instr: IMEM_DATA};
  end

  // Program counter: reset, redirect target, or sequential advance on push.
  always_ff @(posedge CLK) begin
    if (!RST_N)           pc <= align_pc(RESET_PC);
    else if (redirect_en) pc <= align_pc(REDIRECT_PC);
    else if (push)        pc <= pc + XLEN'(PC_STEP);
  end

  fetch_buffer u_fetch_buffer (
    .clk        (CLK),
    .rst_n      (RST_N),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_en),
    .push_entry (push_entry),
    .count      (count),
    .head_valid (INSTR_VALID),
    .head_entry (head_entry)
  );

  // Output mapping.
  always_comb begin
    IMEM_ADDR = pc;
    INSTR     = head_entry.instr;
    INSTR_PC  = head_entry.pc;
  end

endmodule
